// File: rtl/sprite_row_fetcher.sv
// Burst reader: walks Length SRAM words from Base_Addr into a FIFO drained by valid/ready.
// Optional stall statistics port enabled with `define SPRITE_FETCH_STATS_EN.
module sprite_row_fetcher #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [19:0]      Base_Addr,
  input  logic [LEN_W-1:0] Length,
  output logic             Busy,
  output logic             Done,
  output logic [19:0]      SRAM_ADDR,
  output logic             SRAM_CE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_OE_N,
  output logic             SRAM_WE_N,
  input  logic [15:0]      Data_from_SRAM,
  output logic [15:0]      Pix_Data,
  output logic             Pix_Valid,
  input  logic             Pix_Ready
`ifdef SPRITE_FETCH_STATS_EN
  ,
  output logic [15:0]      Stall_Cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, WAIT_FULL} state_t;

  state_t             state, state_nx;
  logic [19:0]        addr, addr_nx;
  logic [LEN_W-1:0]   remain, remain_nx;
  logic               done_nx, busy_nx, rd_n_nx, rd_n;
  logic               start_ok, push, pop, room;
  logic [CNT_W-1:0]   fifo_cnt, cnt_after;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [15:0]        mem [DEPTH];

  assign push      = (state == SAMPLE);
  assign pop       = Pix_Valid && Pix_Ready;
  assign cnt_after = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  assign room      = cnt_after < CNT_W'(DEPTH);
  assign start_ok  = (state == IDLE) && Start && (Length != '0);

  assign Pix_Valid = (fifo_cnt != '0);
  assign Pix_Data  = mem[rd_ptr];

  assign SRAM_CE_N = rd_n;
  assign SRAM_OE_N = rd_n;
  assign SRAM_UB_N = rd_n;
  assign SRAM_LB_N = rd_n;
  assign SRAM_WE_N = 1'b1;

  // Next-state and registered-output values
  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    remain_nx = remain;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          addr_nx   = Base_Addr;
          remain_nx = Length;
          state_nx  = room ? SETUP : WAIT_FULL;
        end else if (Start) begin
          done_nx = 1'b1;
        end
      end
      SETUP: state_nx = SAMPLE;
      SAMPLE: begin
        addr_nx   = addr + 20'd1;
        remain_nx = remain - LEN_W'(1);
        if (remain == LEN_W'(1)) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = room ? SETUP : WAIT_FULL;
        end
      end
      WAIT_FULL: if (room) state_nx = SETUP;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
    rd_n_nx = !((state_nx == SETUP) || (state_nx == SAMPLE));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      rd_n      <= 1'b1;
      SRAM_ADDR <= '0;
    end else begin
      state  <= state_nx;
      addr   <= addr_nx;
      remain <= remain_nx;
      Busy   <= busy_nx;
      Done   <= done_nx;
      rd_n   <= rd_n_nx;
      // Address only moves when a new access begins; it holds through WAIT_FULL
      if (state_nx == SETUP) SRAM_ADDR <= addr_nx;
    end
  end

  // Pixel FIFO: one push per SAMPLE, pop on handshake
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= Data_from_SRAM;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= cnt_after;
    end
  end

`ifdef SPRITE_FETCH_STATS_EN
  // Saturating count of cycles stalled on a full FIFO
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_Cycles <= '0;
    end else if (start_ok) begin
      Stall_Cycles <= '0;
    end else if ((state == WAIT_FULL) && (Stall_Cycles != 16'hFFFF)) begin
      Stall_Cycles <= Stall_Cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Self-checking bench for sprite_row_fetcher: directed corner cases plus randomized bursts
// against a queue-based model of expected pixels and read addresses.
module tb_sprite_row_fetcher;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = 8;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic [19:0]      Base_Addr;
  logic [LEN_W-1:0] Length;
  logic             Busy, Done;
  logic [19:0]      SRAM_ADDR;
  logic             SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  logic [15:0]      Data_from_SRAM;
  logic [15:0]      Pix_Data;
  logic             Pix_Valid;
  logic             Pix_Ready;
`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0]      Stall_Cycles;
`endif

  sprite_row_fetcher #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Base_Addr(Base_Addr), .Length(Length),
    .Busy(Busy), .Done(Done), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .Data_from_SRAM(Data_from_SRAM), .Pix_Data(Pix_Data), .Pix_Valid(Pix_Valid),
    .Pix_Ready(Pix_Ready)
`ifdef SPRITE_FETCH_STATS_EN
    , .Stall_Cycles(Stall_Cycles)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] pix(input logic [19:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // SRAM model: data is a function of the presented address
  assign Data_from_SRAM = pix(SRAM_ADDR);

  int n_checks = 0;
  int n_fail = 0;
  int e = 0;
  int t0 = 0;
  int done_cnt = 0;
  int last_done_e = 0;
  int low_cnt = 0;
  int ce_total = 0;
  bit rand_ready = 0;
  logic [19:0] addr_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, e);
    end
  endtask

  always @(posedge Clk) e <= e + 1;

  always @(posedge Clk) begin
    if (rand_ready) begin
      #1;
      Pix_Ready = 1'($urandom_range(0, 1));
    end
  end

  // Observe completion pulses, read accesses and pixel handshakes
  always @(negedge Clk) begin
    if (Done) begin
      done_cnt++;
      last_done_e = e;
    end
    if (!SRAM_CE_N) begin
      ce_total++;
      low_cnt++;
      if (low_cnt % 2 == 0) begin
        addr_q.push_back(SRAM_ADDR);
        check("we_n_high", 32'(SRAM_WE_N), 32'd1);
        check("oe_n_low", 32'(SRAM_OE_N), 32'd0);
      end
    end
    if (Pix_Valid && Pix_Ready) begin
      if (exp_q.size() == 0) check("spurious_pixel", 32'(Pix_Data), 32'hDEAD);
      else check("pix_data", 32'(Pix_Data), 32'(exp_q.pop_front()));
    end
  end

  task automatic start_burst(input logic [19:0] base, input int len);
    @(posedge Clk); #1;
    Start = 1'b1;
    Base_Addr = base;
    Length = LEN_W'(len);
    low_cnt = 0;
    addr_q.delete();
    @(posedge Clk); #1;
    t0 = e;
    Start = 1'b0;
    for (int i = 0; i < len; i++) exp_q.push_back(pix(20'(base + 20'(i))));
  endtask

  task automatic wait_done(input int d0, input int limit);
    int k = 0;
    while (done_cnt == d0 && k < limit) begin
      @(posedge Clk);
      k++;
    end
    #1;
    check("done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic check_addrs(input logic [19:0] base, input int len);
    check("read_count", 32'(addr_q.size()), 32'(len));
    for (int i = 0; i < len && i < addr_q.size(); i++)
      check("read_addr", 32'(addr_q[i]), 32'(20'(base + 20'(i))));
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge Clk);
      k++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(Pix_Valid), 32'd0);
  endtask

  initial begin
    int d0;
    int ce0;
    logic [19:0] b;
    int len;

    Reset_n = 1'b0; Start = 1'b0; Base_Addr = '0; Length = '0; Pix_Ready = 1'b0;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("rst_valid", 32'(Pix_Valid), 32'd0);
    check("rst_pix", 32'(Pix_Data), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;

    // Basic 4-word burst
    Pix_Ready = 1'b1;
    d0 = done_cnt;
    start_burst(20'h00100, 4);
    check("basic_busy_t1", 32'(Busy), 32'd1);
    @(posedge Clk); #1;
    check("basic_valid_t2", 32'(Pix_Valid), 32'd0);
    @(posedge Clk); #1;
    check("basic_valid_t3", 32'(Pix_Valid), 32'd1);
    check("basic_first_pix", 32'(Pix_Data), 32'h0000A4A5);
    wait_done(d0, 100);
    check("basic_done_lat", 32'(last_done_e - t0), 32'd8);
    check_addrs(20'h00100, 4);
    drain(50);

    // Zero-length burst
    d0 = done_cnt;
    ce0 = ce_total;
    start_burst(20'h12345, 0);
    check("zero_done", 32'(Done), 32'd1);
    check("zero_busy", 32'(Busy), 32'd0);
    @(posedge Clk); #1;
    check("zero_done_pulse", 32'(Done), 32'd0);
    check("zero_busy2", 32'(Busy), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("zero_no_access", 32'(ce_total), 32'(ce0));

    // Back-pressure: FIFO fills, FSM parks with strobes idle
    Pix_Ready = 1'b0;
    d0 = done_cnt;
    b = 20'h0A0F0;
    start_burst(b, 12);
    repeat (40) @(posedge Clk);
    #1;
    check("bp_valid", 32'(Pix_Valid), 32'd1);
    check("bp_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("bp_busy", 32'(Busy), 32'd1);
    check("bp_reads", 32'(addr_q.size()), 32'(DEPTH));
    check("bp_addr_hold", 32'(SRAM_ADDR), 32'(b + 20'(DEPTH - 1)));
`ifdef SPRITE_FETCH_STATS_EN
    check("bp_stall", 32'(Stall_Cycles), 32'(40 - 2 * DEPTH));
`endif
    Pix_Ready = 1'b1;
    wait_done(d0, 200);
    check_addrs(b, 12);
    drain(50);

    // Address wrap
    d0 = done_cnt;
    start_burst(20'hFFFFE, 3);
    wait_done(d0, 100);
    check_addrs(20'hFFFFE, 3);
    drain(50);

    // Reset in the SAMPLE cycle of word 2 of a 6-word burst
    d0 = done_cnt;
    start_burst(20'h00200, 6);
    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("mid_rst_valid", 32'(Pix_Valid), 32'd0);
    check("mid_rst_pix", 32'(Pix_Data), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'(d0));
    check("mid_rst_idle_valid", 32'(Pix_Valid), 32'd0);

    // Start while busy is ignored
    d0 = done_cnt;
    b = 20'h30000;
    start_burst(b, 5);
    repeat (2) @(posedge Clk);
    #1;
    Start = 1'b1; Base_Addr = 20'h55555; Length = LEN_W'(9);
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(d0, 100);
    repeat (30) @(posedge Clk);
    #1;
    check("busy_start_one_done", 32'(done_cnt), 32'(d0 + 1));
    check_addrs(b, 5);
    drain(50);

    // Randomized bursts with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b = 20'($urandom);
      len = int'($urandom_range(1, 20));
      d0 = done_cnt;
      start_burst(b, len);
      wait_done(d0, 3000);
      check_addrs(b, len);
    end
    drain(3000);
    rand_ready = 1'b0;
    @(posedge Clk); #2;
    Pix_Ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
